// File: rtl/lif_pkg.sv
// Shared constants and event type for the LIF spike AER encoder.
// Optional timestamping is enabled with the macro AER_TIMESTAMP_EN.
package lif_pkg;

   localparam int NUM_NEURONS_D = 16;
   localparam int NEURON_ID_W_D = 4;
   localparam int TS_W_D        = 8;

   typedef struct packed {
      logic [NEURON_ID_W_D-1:0] id;
      logic [TS_W_D-1:0]        ts;
   } aer_event_t;

endpackage

// File: rtl/lif_rr_arbiter.sv
// Combinational round-robin grant over the spike request lanes.
// Search starts at ptr and wraps modulo N.
module lif_rr_arbiter
   import lif_pkg::*;
#(
   parameter int N = NUM_NEURONS_D,
   parameter int W = NEURON_ID_W_D
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   input  logic         enable,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   int j;

   // first requesting lane at or after ptr, wrapping
   always_comb begin
      idx = '0;
      any = 1'b0;
      j   = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!any && req[j]) begin
            any = 1'b1;
            idx = j[W-1:0];
         end
      end
   end

   // one-hot acknowledge only when the consumer can take it
   always_comb begin
      grant = '0;
      if (enable && any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/lif_spike_aer_encoder.sv
// Round-robin spike collector serialising winners into an AER stream.
// Define AER_TIMESTAMP_EN to add the timestep counter and aer_ts port.
module lif_spike_aer_encoder
   import lif_pkg::*;
#(
   parameter int NUM_NEURONS = NUM_NEURONS_D,
   parameter int NEURON_ID_W = NEURON_ID_W_D,
   parameter int TS_W        = TS_W_D
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_NEURONS-1:0] spike_valid,
   output logic [NUM_NEURONS-1:0] spike_ready,
   input  logic                   scan_start_en,
   output logic                   aer_valid,
   input  logic                   aer_ready,
   output logic [NEURON_ID_W-1:0] aer_id,
`ifdef AER_TIMESTAMP_EN
   output logic [TS_W-1:0]        aer_ts,
`endif
   output logic                   busy
);

   localparam logic [NEURON_ID_W-1:0] LAST =
      NEURON_ID_W'(NUM_NEURONS - 1);

   logic [NEURON_ID_W-1:0] ptr;
   logic [NEURON_ID_W-1:0] win_idx;
   logic [NUM_NEURONS-1:0] win_grant;
   logic                   win_any;
   logic                   load_en;
   logic                   take;

   assign load_en = ~aer_valid | aer_ready;
   assign take    = load_en & win_any;

   lif_rr_arbiter #(
      .N (NUM_NEURONS),
      .W (NEURON_ID_W)
   ) u_arb (
      .req    (spike_valid),
      .ptr    (ptr),
      .enable (load_en & ~rst),
      .grant  (win_grant),
      .idx    (win_idx),
      .any    (win_any)
   );

   assign spike_ready = win_grant;
   assign busy        = |spike_valid | aer_valid;

   // output slot and round-robin pointer; ptr advances only on a grant
   always_ff @(posedge clk) begin
      if (rst) begin
         aer_valid <= 1'b0;
         aer_id    <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (win_any) begin
            aer_valid <= 1'b1;
            aer_id    <= win_idx;
            ptr       <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
         end else begin
            aer_valid <= 1'b0;
         end
      end
   end

`ifdef AER_TIMESTAMP_EN
   logic [TS_W-1:0] ts;

   // timestep counter, wraps naturally at 2^TS_W
   always_ff @(posedge clk) begin
      if (rst)                ts <= '0;
      else if (scan_start_en) ts <= ts + 1'b1;
   end

   // stamp with the pre-increment timestep of the grant cycle
   always_ff @(posedge clk) begin
      if (rst)       aer_ts <= '0;
      else if (take) aer_ts <= ts;
   end
`else
   logic unused_scan;
   assign unused_scan = scan_start_en & (TS_W != 0) & take;
`endif

endmodule

// File: tb/tb_lif_spike_aer_encoder.sv
// Self-checking bench for lif_spike_aer_encoder.
// Directed scenarios plus a randomized run against a lane-level model.
module tb_lif_spike_aer_encoder;

   localparam int N   = 16;
   localparam int W   = 4;
   localparam int TSW = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] sv;
   logic [N-1:0] sr;
   logic         scan;
   logic         av;
   logic         ardy;
   logic [W-1:0] aid;
   logic         busy;
`ifdef AER_TIMESTAMP_EN
   logic [TSW-1:0] ats;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lif_spike_aer_encoder #(
      .NUM_NEURONS (N),
      .NEURON_ID_W (W),
      .TS_W        (TSW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .spike_valid   (sv),
      .spike_ready   (sr),
      .scan_start_en (scan),
      .aer_valid     (av),
      .aer_ready     (ardy),
      .aer_id        (aid),
`ifdef AER_TIMESTAMP_EN
      .aer_ts        (ats),
`endif
      .busy          (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      sv   = '0;
      scan = 1'b0;
      ardy = 1'b1;
      tick();
      rst  = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      sv   = N'($urandom) | N'(1);
      ardy = 1'b1;
      scan = 1'b0;
      @(negedge clk);
      total++;
      if (sr !== '0) begin
         bad++;
         $display("FAIL reset_ready0 got=%h want=0", sr);
      end
      tick();
      @(negedge clk);
      total++;
      if (sr !== '0) begin
         bad++;
         $display("FAIL reset_ready1 got=%h want=0", sr);
      end
      total++;
      if ({av, aid} !== {1'b0, W'(0)}) begin
         bad++;
         $display("FAIL reset_out got=%b/%0d want=0/0", av, aid);
      end
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_busy got=%b want=1", busy);
      end
`ifdef AER_TIMESTAMP_EN
      total++;
      if (ats !== '0) begin
         bad++;
         $display("FAIL reset_ts got=%0d want=0", ats);
      end
`endif
      tick();
      rst = 1'b0;
      sv  = '0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_busy got=%b want=0", busy);
      end
      tick();
   endtask

   task automatic test_single();
      do_reset();
      sv = N'(1) << 5;
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 5 || av !== 1'b0) begin
         bad++;
         $display("FAIL single_ack got=%h/%b want=0020/0", sr, av);
      end
      tick();
      sv = '0;
      @(negedge clk);
      total++;
      if ({av, aid} !== {1'b1, W'(5)} || sr !== '0) begin
         bad++;
         $display("FAIL single_evt got=%b/%0d want=1/5", av, aid);
      end
      tick();
      sv = N'(1) | (N'(1) << 6);
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 6 || av !== 1'b0) begin
         bad++;
         $display("FAIL single_ptr6 got=%h/%b want=0040/0", sr, av);
      end
      tick();
      sv = N'(1);
      @(negedge clk);
      total++;
      if (aid !== W'(6) || sr !== N'(1)) begin
         bad++;
         $display("FAIL single_next got=%0d/%h want=6/0001", aid, sr);
      end
      tick();
      sv = '0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] ack;
      logic [N-1:0] e;
      do_reset();
      sv = '1;
      for (int c = 0; c <= N; c++) begin
         @(negedge clk);
         ack = sr;
         if (c < N) begin
            e    = '0;
            e[c] = 1'b1;
            total++;
            if (sr !== e) begin
               bad++;
               $display("FAIL b2b_ready c=%0d got=%h want=%h", c, sr, e);
            end
         end
         if (c >= 1) begin
            total++;
            if ({av, aid} !== {1'b1, W'(c - 1)}) begin
               bad++;
               $display("FAIL b2b_evt c=%0d got=%b/%0d want=1/%0d",
                        c, av, aid, c - 1);
            end
         end
         tick();
         sv = sv & ~ack;
      end
      total++;
      if (sv !== '0) begin
         bad++;
         $display("FAIL b2b_left got=%h want=0", sv);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      sv = N'(1) << 3;
      tick();
      sv   = (N'(1) << 3) | (N'(1) << 9);
      ardy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         total++;
         if ({av, aid} !== {1'b1, W'(3)} || sr !== '0) begin
            bad++;
            $display("FAIL bp_hold c=%0d got=%b/%0d/%h want=1/3/0000",
                     c, av, aid, sr);
         end
         tick();
      end
      ardy = 1'b1;
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 9) begin
         bad++;
         $display("FAIL bp_release got=%h want=0200", sr);
      end
      tick();
      sv = N'(1) << 3;
      @(negedge clk);
      total++;
      if (aid !== W'(9) || sr !== N'(1) << 3) begin
         bad++;
         $display("FAIL bp_next got=%0d/%h want=9/0008", aid, sr);
      end
      tick();
      sv = '0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      sv = N'(1) << 13;
      tick();
      sv = (N'(1) << 2) | (N'(1) << 15);
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 15) begin
         bad++;
         $display("FAIL wrap_15 got=%h want=8000", sr);
      end
      tick();
      sv = N'(1) << 2;
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 2 || aid !== W'(15)) begin
         bad++;
         $display("FAIL wrap_2 got=%h/%0d want=0004/15", sr, aid);
      end
      tick();
      sv = (N'(1) << 1) | (N'(1) << 3);
      @(negedge clk);
      total++;
      if (sr !== N'(1) << 3 || aid !== W'(2)) begin
         bad++;
         $display("FAIL wrap_ptr3 got=%h/%0d want=0008/2", sr, aid);
      end
      tick();
      sv = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
`ifdef AER_TIMESTAMP_EN
      scan = 1'b1;
      tick();
      tick();
      scan = 1'b0;
`endif
      sv = N'(1) << 7;
      tick();
      ardy = 1'b0;
      @(negedge clk);
      total++;
      if ({av, aid} !== {1'b1, W'(7)}) begin
         bad++;
         $display("FAIL mid_pre got=%b/%0d want=1/7", av, aid);
      end
      tick();
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (sr !== '0) begin
         bad++;
         $display("FAIL mid_rst_ready got=%h want=0", sr);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (av !== 1'b0 || sr !== N'(1) << 7) begin
         bad++;
         $display("FAIL mid_after got=%b/%h want=0/0080", av, sr);
      end
      tick();
      sv = '0;
      @(negedge clk);
      total++;
      if ({av, aid} !== {1'b1, W'(7)}) begin
         bad++;
         $display("FAIL mid_regrant got=%b/%0d want=1/7", av, aid);
      end
`ifdef AER_TIMESTAMP_EN
      total++;
      if (ats !== '0) begin
         bad++;
         $display("FAIL mid_ts got=%0d want=0", ats);
      end
`endif
      ardy = 1'b1;
      tick();
      tick();
   endtask

`ifdef AER_TIMESTAMP_EN
   task automatic test_timestamp();
      do_reset();
      scan = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      scan = 1'b0;
      sv   = N'(1) << 1;
      tick();
      sv = '0;
      @(negedge clk);
      total++;
      if (ats !== TSW'(3)) begin
         bad++;
         $display("FAIL ts_three got=%0d want=3", ats);
      end
      scan = 1'b1;
      sv   = N'(1) << 2;
      tick();
      scan = 1'b0;
      sv   = N'(1) << 3;
      @(negedge clk);
      total++;
      if (ats !== TSW'(3) || aid !== W'(2)) begin
         bad++;
         $display("FAIL ts_same got=%0d/%0d want=3/2", ats, aid);
      end
      tick();
      sv = '0;
      @(negedge clk);
      total++;
      if (ats !== TSW'(4) || aid !== W'(3)) begin
         bad++;
         $display("FAIL ts_four got=%0d/%0d want=4/3", ats, aid);
      end
      do_reset();
      scan = 1'b1;
      for (int i = 0; i < (1 << TSW); i++) tick();
      scan = 1'b0;
      sv   = N'(1) << 4;
      tick();
      sv = '0;
      @(negedge clk);
      total++;
      if (ats !== '0) begin
         bad++;
         $display("FAIL ts_wrap got=%0d want=0", ats);
      end
      tick();
   endtask
`endif

   task automatic test_random();
      logic [N-1:0] pend;
      logic [N-1:0] exp_sr;
      int           waitc [N];
      int           m_ptr;
      int           m_id;
      int           m_ts;
      int           m_evts;
      bit           m_valid;
      bit           ld;
      int           g;
      int           idx;
      do_reset();
      pend    = '0;
      m_ptr   = 0;
      m_id    = 0;
      m_ts    = 0;
      m_evts  = 0;
      m_valid = 1'b0;
      for (int i = 0; i < N; i++) waitc[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (pend[i] && $urandom_range(31) == 0) begin
               pend[i]  = 1'b0;
               waitc[i] = 0;
            end else if (!pend[i] && $urandom_range(3) == 0) begin
               pend[i]  = 1'b1;
               waitc[i] = 0;
            end
         end
         sv   = pend;
         ardy = ($urandom_range(3) != 0);
         scan = ($urandom_range(7) == 0);
         @(negedge clk);
         ld = !m_valid || ardy;
         g  = -1;
         if (ld) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (g < 0 && pend[idx]) g = idx;
            end
         end
         exp_sr = '0;
         if (g >= 0) exp_sr[g] = 1'b1;
         total++;
         if (sr !== exp_sr) begin
            bad++;
            $display("FAIL rnd_ready cyc=%0d got=%h want=%h", cyc, sr, exp_sr);
         end
         total++;
         if (av !== m_valid || busy !== (pend != '0 || m_valid)) begin
            bad++;
            $display("FAIL rnd_valid cyc=%0d got=%b/%b want=%b", cyc, av,
                     busy, m_valid);
         end
         if (m_valid) begin
            total++;
            if (aid !== W'(m_id)) begin
               bad++;
               $display("FAIL rnd_id cyc=%0d got=%0d want=%0d", cyc, aid, m_id);
            end
`ifdef AER_TIMESTAMP_EN
            total++;
            if (ats !== TSW'(m_evts)) begin
               bad++;
               $display("FAIL rnd_ts cyc=%0d got=%0d want=%0d", cyc, ats,
                        m_evts);
            end
`endif
         end
         @(posedge clk);
         if (ld) begin
            if (g >= 0) begin
               m_valid = 1'b1;
               m_id    = g;
               m_evts  = m_ts;
               m_ptr   = (g + 1) % N;
               pend[g] = 1'b0;
               waitc[g] = 0;
               for (int i = 0; i < N; i++) begin
                  if (pend[i]) begin
                     waitc[i]++;
                     total++;
                     if (waitc[i] >= N) begin
                        bad++;
                        $display("FAIL rnd_fair lane=%0d waited=%0d want<%0d",
                                 i, waitc[i], N);
                     end
                  end
               end
            end else begin
               m_valid = 1'b0;
            end
         end
         if (scan) m_ts = (m_ts + 1) % (1 << TSW);
         #1;
      end
      sv   = '0;
      ardy = 1'b1;
      scan = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      rst  = 1'b1;
      sv   = '0;
      scan = 1'b0;
      ardy = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid();
`ifdef AER_TIMESTAMP_EN
      test_timestamp();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
